// File: rtl/dsp_rx_irq_ctrl_if.sv
// Request/acknowledge and status bundle between the store/readout stage, the DSP
// and the receive interrupt controller.
interface dsp_rx_irq_ctrl_if;
   logic        read_quest;
   logic        dsp_ack;
   logic        slot_interrupt;
   logic        irq_enable;
   logic        dsp_receive_interrupt;
   logic        busy;
   logic        irq_pending;
   logic [10:0] irq_count_slot;
   logic [10:0] irq_count_last;
   logic [7:0]  overrun_count;
   logic [7:0]  timeout_count;

   modport master (
      output read_quest, dsp_ack, slot_interrupt, irq_enable,
      input  dsp_receive_interrupt, busy, irq_pending,
      input  irq_count_slot, irq_count_last, overrun_count, timeout_count
   );

   modport slave (
      input  read_quest, dsp_ack, slot_interrupt, irq_enable,
      output dsp_receive_interrupt, busy, irq_pending,
      output irq_count_slot, irq_count_last, overrun_count, timeout_count
   );
endinterface

// File: rtl/dsp_rx_irq_ctrl.sv
// Turns store-ram read requests into fixed-width DSP receive interrupts, tracks the
// DSP acknowledge, queues one request while busy and keeps overrun/timeout/slot counts.
module dsp_rx_irq_ctrl #(
   parameter int unsigned IRQ_WIDTH   = 100,
   parameter int unsigned ACK_TIMEOUT = 5000
) (
   input  logic             clk_50m,
   input  logic             cfg_rst,
   dsp_rx_irq_ctrl_if.slave bus
);

   localparam int unsigned WCNT_W = $clog2(IRQ_WIDTH + 1);
   localparam int unsigned TCNT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(IRQ_WIDTH - 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ASSERT,
      S_WAIT_ACK
   } state_e;

   state_e            state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
   logic              ack_seen_q, ack_seen_d;
   logic              pend_q, pend_d;
   logic [7:0]        ovr_q, ovr_d;
   logic [7:0]        tmo_q, tmo_d;
   logic [10:0]       slot_q, slot_d;
   logic [10:0]       last_q, last_d;

   logic              rq_d_q;
   logic              rq_arm_q;
   logic              ack_s1_q, ack_s2_q, ack_s3_q;

   logic              req_edge;
   logic              ack_edge;
   logic              start;
   logic              tmo_hit;

   // rq_arm_q stays low until read_quest is seen low, so a level held across reset
   // release is not mistaken for a fresh request.
   assign req_edge = bus.read_quest & ~rq_d_q & rq_arm_q;
   assign ack_edge = ack_s2_q & ~ack_s3_q;

   always_ff @(posedge clk_50m or posedge cfg_rst) begin
      if (cfg_rst) begin
         rq_d_q   <= 1'b0;
         rq_arm_q <= 1'b0;
         ack_s1_q <= 1'b0;
         ack_s2_q <= 1'b0;
         ack_s3_q <= 1'b0;
      end else begin
         rq_d_q   <= bus.read_quest;
         rq_arm_q <= rq_arm_q | ~bus.read_quest;
         ack_s1_q <= bus.dsp_ack;
         ack_s2_q <= ack_s1_q;
         ack_s3_q <= ack_s2_q;
      end
   end

   always_ff @(posedge clk_50m or posedge cfg_rst) begin
      if (cfg_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      tcnt_d     = tcnt_q;
      ack_seen_d = ack_seen_q;
      start      = 1'b0;
      tmo_hit    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.irq_enable & (req_edge | pend_q)) begin
               state_d    = S_ASSERT;
               wcnt_d     = '0;
               ack_seen_d = 1'b0;
               start      = 1'b1;
            end
         end
         S_ASSERT: begin
            if (ack_edge) begin
               ack_seen_d = 1'b1;
            end
            if (wcnt_q == WCNT_LAST) begin
               state_d = (ack_seen_q | ack_edge) ? S_IDLE : S_WAIT_ACK;
               tcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         S_WAIT_ACK: begin
            if (ack_edge) begin
               state_d = S_IDLE;
            end else if (tcnt_q == TCNT_LAST) begin
               state_d = S_IDLE;
               tmo_hit = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      pend_d = pend_q;
      ovr_d  = ovr_q;
      tmo_d  = tmo_q;
      slot_d = slot_q;
      last_d = last_q;

      if (!bus.irq_enable || start) begin
         pend_d = 1'b0;
      end else if (req_edge && (state_q != S_IDLE)) begin
         if (!pend_q) begin
            pend_d = 1'b1;
         end else if (ovr_q != '1) begin
            ovr_d = ovr_q + 1'b1;
         end
      end

      if (tmo_hit && (tmo_q != '1)) begin
         tmo_d = tmo_q + 1'b1;
      end

      // An interrupt starting on the slot boundary belongs to the new slot.
      if (bus.slot_interrupt) begin
         last_d = slot_q;
         slot_d = start ? 11'd1 : '0;
      end else if (start && (slot_q != '1)) begin
         slot_d = slot_q + 1'b1;
      end
   end

   always_ff @(posedge clk_50m or posedge cfg_rst) begin
      if (cfg_rst) begin
         wcnt_q     <= '0;
         tcnt_q     <= '0;
         ack_seen_q <= 1'b0;
         pend_q     <= 1'b0;
         ovr_q      <= '0;
         tmo_q      <= '0;
         slot_q     <= '0;
         last_q     <= '0;
      end else begin
         wcnt_q     <= wcnt_d;
         tcnt_q     <= tcnt_d;
         ack_seen_q <= ack_seen_d;
         pend_q     <= pend_d;
         ovr_q      <= ovr_d;
         tmo_q      <= tmo_d;
         slot_q     <= slot_d;
         last_q     <= last_d;
      end
   end

   assign bus.dsp_receive_interrupt = (state_q == S_ASSERT);
   assign bus.busy                  = (state_q != S_IDLE);
   assign bus.irq_pending           = pend_q;
   assign bus.irq_count_slot        = slot_q;
   assign bus.irq_count_last        = last_q;
   assign bus.overrun_count         = ovr_q;
   assign bus.timeout_count         = tmo_q;

endmodule

// File: tb/tb_dsp_rx_irq_ctrl.sv
// Directed scoreboard bench for dsp_rx_irq_ctrl: stimulus queues expected status
// snapshots and interrupt pulses, a negedge monitor pops and compares them.
module tb_dsp_rx_irq_ctrl;

   typedef struct {
      int    at;
      string name;
      int    irq, busy, pend, slot, last, ovr, tmo;
   } exp_t;

   typedef struct {
      int start;
      int width;
   } pulse_t;

   logic   clk_50m = 1'b0;
   logic   cfg_rst;
   int     cyc = 0;
   int     n_err = 0;
   int     n_chk = 0;
   bit     done = 1'b0;
   exp_t   chk_q[$];
   pulse_t pulse_q[$];

   dsp_rx_irq_ctrl_if bus ();

   dsp_rx_irq_ctrl #(
      .IRQ_WIDTH  (100),
      .ACK_TIMEOUT(5000)
   ) dut (
      .clk_50m(clk_50m),
      .cfg_rst(cfg_rst),
      .bus    (bus)
   );

   always #10 clk_50m = ~clk_50m;
   always @(posedge clk_50m) cyc <= cyc + 1;

   task automatic go(input int c);
      while (cyc < c) begin
         @(posedge clk_50m);
         #1;
      end
   endtask

   task automatic expect_at(input int at, input string name, input int irq, input int busy,
                            input int pend, input int slot, input int last, input int ovr,
                            input int tmo);
      exp_t e;
      e.at = at; e.name = name; e.irq = irq; e.busy = busy; e.pend = pend;
      e.slot = slot; e.last = last; e.ovr = ovr; e.tmo = tmo;
      chk_q.push_back(e);
   endtask

   task automatic expect_pulse(input int start, input int width);
      pulse_t p;
      p.start = start;
      p.width = width;
      pulse_q.push_back(p);
   endtask

   task automatic pulse_rq(input int c);
      go(c);
      bus.read_quest = 1'b1;
      go(c + 2);
      bus.read_quest = 1'b0;
   endtask

   task automatic pulse_ack(input int c);
      go(c);
      bus.dsp_ack = 1'b1;
      go(c + 2);
      bus.dsp_ack = 1'b0;
   endtask

   task automatic do_reset();
      cfg_rst            = 1'b1;
      bus.read_quest     = 1'b0;
      bus.dsp_ack        = 1'b0;
      bus.slot_interrupt = 1'b0;
      bus.irq_enable     = 1'b1;
      go(cyc + 3);
      cfg_rst = 1'b0;
      go(cyc + 2);
   endtask

   // Stimulus
   initial begin
      int b;
      int k;
      int p;

      // 1: single request, held high, ack during ASSERT
      do_reset();
      b = cyc;
      expect_at(b, "reset", 0, 0, 0, 0, 0, 0, 0);
      expect_pulse(b + 11, 100);
      expect_at(b + 110, "t1_last_high", 1, 1, 0, 1, 0, 0, 0);
      expect_at(b + 111, "t1_idle", 0, 0, 0, 1, 0, 0, 0);
      expect_at(b + 400, "t1_held_high", 0, 0, 0, 1, 0, 0, 0);
      go(b + 10);
      bus.read_quest = 1'b1;
      pulse_ack(b + 50);
      go(b + 510);
      bus.read_quest = 1'b0;

      // 2: pending request, back-to-back service, irq_enable gating
      do_reset();
      b = cyc;
      expect_pulse(b + 11, 100);
      expect_pulse(b + 112, 100);
      expect_pulse(b + 251, 100);
      expect_at(b + 41,  "t2_pend_set",  1, 1, 1, 1, 0, 0, 0);
      expect_at(b + 111, "t2_gap",       0, 0, 1, 1, 0, 0, 0);
      expect_at(b + 112, "t2_second",    1, 1, 0, 2, 0, 0, 0);
      expect_at(b + 212, "t2_done",      0, 0, 0, 2, 0, 0, 0);
      expect_at(b + 240, "t2_disabled",  0, 0, 0, 2, 0, 0, 0);
      expect_at(b + 261, "t2_pend_en",   1, 1, 1, 3, 0, 0, 0);
      expect_at(b + 272, "t2_pend_drop", 1, 1, 0, 3, 0, 0, 0);
      expect_at(b + 400, "t2_end",       0, 0, 0, 3, 0, 0, 0);
      pulse_rq(b + 10);
      pulse_rq(b + 40);
      pulse_ack(b + 50);
      pulse_ack(b + 150);
      go(b + 220);
      bus.irq_enable = 1'b0;
      pulse_rq(b + 230);
      go(b + 250);
      bus.irq_enable = 1'b1;
      pulse_rq(b + 250);
      pulse_rq(b + 260);
      go(b + 270);
      bus.irq_enable = 1'b0;
      pulse_ack(b + 300);
      go(b + 360);
      bus.irq_enable = 1'b1;
      go(b + 410);

      // 3: triples of edges while busy, overrun saturation
      do_reset();
      b = cyc;
      expect_pulse(b + 11, 100);
      expect_at(b + 30,   "t3_triple",  1, 1, 1, 1, 0, 1, 0);
      expect_at(b + 52,   "t3_more",    1, 1, 1, 1, 0, 4, 0);
      expect_at(b + 1052, "t3_ovr254",  0, 1, 1, 1, 0, 254, 0);
      expect_at(b + 1056, "t3_ovr255",  0, 1, 1, 1, 0, 255, 0);
      expect_at(b + 3700, "t3_sat",     0, 1, 1, 1, 0, 255, 0);
      go(b + 10);
      bus.read_quest = 1'b1;
      go(b + 15);
      bus.read_quest = 1'b0;
      go(b + 17);
      bus.read_quest = 1'b1;
      go(b + 20);
      bus.read_quest = 1'b0;
      go(b + 22);
      bus.read_quest = 1'b1;
      p = b + 40;
      for (int i = 0; i < 897; i++) begin
         go(p);
         bus.read_quest = 1'b0;
         go(p + 2);
         bus.read_quest = 1'b1;
         p += 4;
      end
      go(p);
      bus.read_quest = 1'b0;
      go(b + 3701);

      // 4: ack timeout, then ack landing on the final timeout cycle
      do_reset();
      b = cyc;
      k = b + 5200;
      expect_pulse(b + 11, 100);
      expect_pulse(k + 1, 100);
      expect_at(b + 111,  "t4_wait",      0, 1, 0, 1, 0, 0, 0);
      expect_at(b + 5110, "t4_wait_end",  0, 1, 0, 1, 0, 0, 0);
      expect_at(b + 5111, "t4_timeout",   0, 0, 0, 1, 0, 0, 1);
      expect_at(k + 5100, "t4_race_wait", 0, 1, 0, 2, 0, 0, 1);
      expect_at(k + 5101, "t4_race_ack",  0, 0, 0, 2, 0, 0, 1);
      pulse_rq(b + 10);
      pulse_rq(k);
      pulse_ack(k + 5098);
      go(k + 5110);

      // 6: reset in the middle of ASSERT with a pending request
      b = cyc;
      expect_pulse(b + 11, 39);
      expect_pulse(b + 216, 100);
      expect_at(b + 30,  "t6_pending",   1, 1, 1, 3, 0, 0, 1);
      expect_at(b + 50,  "t6_async_rst", 0, 0, 0, 0, 0, 0, 0);
      expect_at(b + 60,  "t6_after_rel", 0, 0, 0, 0, 0, 0, 0);
      expect_at(b + 200, "t6_held",      0, 0, 0, 0, 0, 0, 0);
      expect_at(b + 216, "t6_fresh",     1, 1, 0, 1, 0, 0, 0);
      expect_at(b + 320, "t6_end",       0, 0, 0, 1, 0, 0, 0);
      pulse_rq(b + 10);
      go(b + 20);
      bus.read_quest = 1'b1;
      go(b + 50);
      cfg_rst = 1'b1;
      go(b + 53);
      cfg_rst = 1'b0;
      go(b + 210);
      bus.read_quest = 1'b0;
      go(b + 215);
      bus.read_quest = 1'b1;
      pulse_ack(b + 250);
      go(b + 330);
      bus.read_quest = 1'b0;

      // 5: slot counting and the slot boundary coinciding with a new interrupt
      do_reset();
      b = cyc;
      for (int i = 0; i < 5; i++) expect_pulse(b + 11 + 120 * i, 100);
      expect_pulse(b + 611, 100);
      expect_pulse(b + 731, 100);
      expect_pulse(b + 861, 100);
      expect_at(b + 600, "t5_before_slot", 0, 0, 0, 5, 0, 0, 0);
      expect_at(b + 601, "t5_slot",        0, 0, 0, 0, 5, 0, 0);
      expect_at(b + 840, "t5_two",         0, 0, 0, 2, 5, 0, 0);
      expect_at(b + 861, "t5_coincide",    1, 1, 0, 1, 2, 0, 0);
      expect_at(b + 970, "t5_end",         0, 0, 0, 1, 2, 0, 0);
      for (int i = 0; i < 5; i++) begin
         pulse_rq(b + 10 + 120 * i);
         pulse_ack(b + 40 + 120 * i);
      end
      go(b + 600);
      bus.slot_interrupt = 1'b1;
      go(b + 601);
      bus.slot_interrupt = 1'b0;
      pulse_rq(b + 610);
      pulse_ack(b + 640);
      pulse_rq(b + 730);
      pulse_ack(b + 760);
      go(b + 860);
      bus.read_quest     = 1'b1;
      bus.slot_interrupt = 1'b1;
      go(b + 861);
      bus.slot_interrupt = 1'b0;
      go(b + 862);
      bus.read_quest = 1'b0;
      pulse_ack(b + 880);
      go(b + 1000);

      done = 1'b1;
   end

   // Monitor / scoreboard
   initial begin
      exp_t   e;
      pulse_t p;
      logic   irq_prev;
      int     rise;
      irq_prev = 1'b0;
      rise     = 0;
      forever begin
         @(negedge clk_50m);
         while (chk_q.size() > 0 && chk_q[0].at <= cyc) begin
            e = chk_q.pop_front();
            n_chk++;
            if (e.at != cyc) begin
               n_err++;
               $display("FAIL %s: got no sample at cycle %0d (now %0d), want one", e.name, e.at, cyc);
            end else if (int'(bus.dsp_receive_interrupt) != e.irq || int'(bus.busy) != e.busy ||
                         int'(bus.irq_pending) != e.pend || int'(bus.irq_count_slot) != e.slot ||
                         int'(bus.irq_count_last) != e.last || int'(bus.overrun_count) != e.ovr ||
                         int'(bus.timeout_count) != e.tmo) begin
               n_err++;
               $display("FAIL %s @%0d: got irq=%0d busy=%0d pend=%0d slot=%0d last=%0d ovr=%0d tmo=%0d, want irq=%0d busy=%0d pend=%0d slot=%0d last=%0d ovr=%0d tmo=%0d",
                        e.name, cyc, bus.dsp_receive_interrupt, bus.busy, bus.irq_pending,
                        bus.irq_count_slot, bus.irq_count_last, bus.overrun_count, bus.timeout_count,
                        e.irq, e.busy, e.pend, e.slot, e.last, e.ovr, e.tmo);
            end
         end

         if (bus.dsp_receive_interrupt === 1'b1 && irq_prev == 1'b0) rise = cyc;
         if (bus.dsp_receive_interrupt !== 1'b1 && irq_prev == 1'b1) begin
            n_chk++;
            if (pulse_q.size() == 0) begin
               n_err++;
               $display("FAIL pulse: got start=%0d width=%0d, want none", rise, cyc - rise);
            end else begin
               p = pulse_q.pop_front();
               if (p.start != rise || p.width != cyc - rise) begin
                  n_err++;
                  $display("FAIL pulse: got start=%0d width=%0d, want start=%0d width=%0d",
                           rise, cyc - rise, p.start, p.width);
               end
            end
         end
         irq_prev = (bus.dsp_receive_interrupt === 1'b1);

         if (done || cyc > 60000) begin
            n_chk++;
            if (!done) begin
               n_err++;
               $display("FAIL watchdog: got cycle %0d without completion, want completion", cyc);
            end else if (chk_q.size() != 0 || pulse_q.size() != 0) begin
               n_err++;
               $display("FAIL drain: got %0d checks and %0d pulses outstanding, want 0 and 0",
                        chk_q.size(), pulse_q.size());
            end
            $display("Result: errors=%0d of %0d checks", n_err, n_chk);
            $finish;
         end
      end
   end

endmodule
